// File: rtl/mem_resp_collect_pkg.sv
// Shared pipes package: collector state type and beat-count helper.
package mem_resp_collect_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } collect_state_e;

  // Requested beat count forced into [1, max_beats]; zero means one beat.
  function automatic int unsigned clamp_beats(input int unsigned req,
                                               input int unsigned max_beats);
    if (req == 0) begin
      return 1;
    end else if (req > max_beats) begin
      return max_beats;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/mem_resp_collect.sv
// Memory response collector: assembles up to NBEATS response beats into one line
// while the pipeline is stalled, then holds the result with finish until the
// stall drops.
// Optional feature macro: MEM_RESP_ERR_EN (sticky error on any captured bad beat).
module mem_resp_collect
  import mem_resp_collect_pkg::*;
#(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned NBEATS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         handshake_stall,
  input  logic [$clog2(NBEATS+1)-1:0]  req_beats,
  input  logic                         data_ok,
  input  logic [BEAT_W-1:0]            read_data,
  input  logic                         resp_err,
  output logic                         finish,
  output logic [BEAT_W*NBEATS-1:0]     store_data,
  output logic [$clog2(NBEATS+1)-1:0]  beats_done,
  output logic                         err
);

  localparam int unsigned CntW  = $clog2(NBEATS + 1);
  localparam int unsigned LineW = BEAT_W * NBEATS;

  collect_state_e   state_q, state_d;
  logic [CntW-1:0]  target_q, target_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LineW-1:0] line_q, line_d;
  logic             err_q, err_d;
  logic             capture;

`ifndef MEM_RESP_ERR_EN
  logic unused_resp_err;
  assign unused_resp_err = resp_err;
`endif

  // Next-state: stall low abandons everything; otherwise collect beats until target.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    err_d    = err_q;
    capture  = 1'b0;

    if (!handshake_stall) begin
      state_d = StIdle;
      cnt_d   = '0;
      line_d  = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          target_d = CntW'(clamp_beats(32'(req_beats), NBEATS));
          state_d  = StCollect;
          cnt_d    = '0;
          line_d   = '0;
          err_d    = 1'b0;
          capture  = data_ok;
        end
        StCollect: capture = data_ok;
        StDone:    capture = 1'b0;
        default:   state_d = StIdle;
      endcase

      if (capture) begin
        for (int k = 0; k < int'(NBEATS); k++) begin
          if (CntW'(k) == cnt_d) begin
            line_d[k*BEAT_W +: BEAT_W] = read_data;
          end
        end
`ifdef MEM_RESP_ERR_EN
        if (resp_err) begin
          err_d = 1'b1;
        end
`endif
        cnt_d = cnt_d + CntW'(1);
        if (cnt_d == target_d) begin
          state_d = StDone;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      target_q <= CntW'(1);
      cnt_q    <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      err_q    <= err_d;
    end
  end

  assign finish     = (state_q == StDone);
  assign store_data = line_q;
  assign beats_done = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_resp_collect.sv
// Self-checking bench for mem_resp_collect (BEAT_W=64, NBEATS=4): directed
// scenarios with literal expectations plus randomized traffic against a
// queue-based model of the collected line.
module tb_mem_resp_collect;

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned NBEATS = 4;
  localparam int unsigned CW     = $clog2(NBEATS + 1);
  localparam int unsigned LW     = BEAT_W * NBEATS;

  logic              clk = 1'b0;
  logic              reset;
  logic              handshake_stall;
  logic [CW-1:0]     req_beats;
  logic              data_ok;
  logic [BEAT_W-1:0] read_data;
  logic              resp_err;
  logic              finish;
  logic [LW-1:0]     store_data;
  logic [CW-1:0]     beats_done;
  logic              err;

  int errors = 0;
  int checks = 0;

`ifdef MEM_RESP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  mem_resp_collect #(
    .BEAT_W(BEAT_W),
    .NBEATS(NBEATS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .handshake_stall(handshake_stall),
    .req_beats      (req_beats),
    .data_ok        (data_ok),
    .read_data      (read_data),
    .resp_err       (resp_err),
    .finish         (finish),
    .store_data     (store_data),
    .beats_done     (beats_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a request is a list of captured beats plus a goal count.
  logic [BEAT_W-1:0] m_beats[$];
  bit                m_active = 0;
  int                m_need   = 1;
  bit                m_err    = 0;

  function automatic logic [LW-1:0] m_line();
    logic [LW-1:0] v = '0;
    for (int k = 0; k < m_beats.size(); k++) v[k*BEAT_W +: BEAT_W] = m_beats[k];
    return v;
  endfunction

  // Compare against the model, then advance it with the inputs the next edge sees.
  always @(negedge clk) begin
    logic          exp_fin;
    logic [LW-1:0] exp_line;
    exp_fin  = m_active && (m_beats.size() == m_need);
    exp_line = m_line();
    checks++;
    if (finish !== exp_fin || store_data !== exp_line ||
        beats_done !== CW'(m_beats.size()) || err !== m_err) begin
      errors++;
      $display("FAIL model t=%0t: got fin=%b bd=%0d err=%b line=%h, want fin=%b bd=%0d err=%b line=%h",
               $time, finish, beats_done, err, store_data,
               exp_fin, m_beats.size(), m_err, exp_line);
    end
    if (reset || !handshake_stall) begin
      m_active = 0;
      m_beats.delete();
      m_err = 0;
    end else begin
      bit take;
      if (!m_active) begin
        m_active = 1;
        m_need   = (req_beats == 0) ? 1 : ((req_beats > NBEATS) ? NBEATS : int'(req_beats));
        m_beats.delete();
        m_err    = 0;
        take     = data_ok;
      end else begin
        take = data_ok && (m_beats.size() < m_need);
      end
      if (take) begin
        m_beats.push_back(read_data);
        if (ErrEn && resp_err) m_err = 1;
      end
    end
  end

  task automatic drive(input bit st, input int rb, input bit dok,
                       input logic [BEAT_W-1:0] d, input bit re = 0);
    handshake_stall = st;
    req_beats       = CW'(rb);
    data_ok         = dok;
    read_data       = d;
    resp_err        = re;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1; handshake_stall = 0; req_beats = '0; data_ok = 0; read_data = '0; resp_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fin", LW'(finish), '0);
    chk("reset_line", store_data, '0);
    reset = 0;
    drive(0, 0, 0, '0);

    // Four back-to-back beats.
    drive(1, 4, 1, 64'h11);
    drive(1, 4, 1, 64'h22);
    drive(1, 4, 1, 64'h33);
    chk("four_not_yet", LW'(finish), '0);
    drive(1, 4, 1, 64'h44);
    chk("four_fin", LW'(finish), 1);
    chk("four_line", store_data, {64'h44, 64'h33, 64'h22, 64'h11});
    chk("four_cnt", LW'(beats_done), 4);
    drive(0, 0, 0, '0);
    chk("drop_line", store_data, '0);
    chk("drop_fin", LW'(finish), '0);

    // Two beats with a gap, then an ignored extra beat in DONE.
    drive(1, 2, 1, 64'hA);
    repeat (3) drive(1, 2, 0, 64'hFF);
    drive(1, 2, 1, 64'hB);
    chk("two_fin", LW'(finish), 1);
    chk("two_line", store_data, {64'h0, 64'h0, 64'hB, 64'hA});
    drive(1, 2, 1, 64'hC);
    chk("two_hold", store_data, {64'h0, 64'h0, 64'hB, 64'hA});
    drive(0, 0, 1, 64'hD);
    chk("ignored_unstalled", LW'(beats_done), '0);

    // Clamping: 0 -> 1 beat, 7 -> 4 beats.
    drive(1, 0, 1, 64'h5);
    chk("clamp0_fin", LW'(finish), 1);
    chk("clamp0_cnt", LW'(beats_done), 1);
    drive(0, 0, 0, '0);
    drive(1, 7, 1, 64'h1);
    drive(1, 7, 1, 64'h2);
    drive(1, 7, 1, 64'h3);
    chk("clamp7_wait", LW'(finish), '0);
    drive(1, 7, 1, 64'h4);
    chk("clamp7_fin", LW'(finish), 1);
    drive(0, 0, 0, '0);

    // Abandon after two of four beats, then a fresh single-beat request.
    drive(1, 4, 1, 64'h77);
    drive(1, 4, 1, 64'h88);
    drive(0, 4, 0, '0);
    chk("abandon_line", store_data, '0);
    chk("abandon_cnt", LW'(beats_done), '0);
    drive(1, 1, 1, 64'h99);
    chk("fresh_line", store_data, {192'h0, 64'h99});

    // Reset while holding DONE.
    drive(1, 1, 0, '0);
    reset = 1;
    drive(1, 1, 0, '0);
    reset = 0;
    chk("rst_done_fin", LW'(finish), '0);
    chk("rst_done_line", store_data, '0);
    drive(0, 0, 0, '0);

    // Error on beat 1 of 3.
    drive(1, 3, 1, 64'h1, 0);
    drive(1, 3, 1, 64'h2, 1);
    chk("err_set", LW'(err), LW'(ErrEn));
    drive(1, 3, 1, 64'h3, 0);
    chk("err_fin", LW'(finish), 1);
    chk("err_hold", LW'(err), LW'(ErrEn));
    drive(0, 0, 0, '0);
    chk("err_clear", LW'(err), '0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 99) < 92), $urandom_range(0, 7), $urandom_range(0, 1),
            {$urandom, $urandom}, $urandom_range(0, 1));
    end
    reset = 0;
    drive(0, 0, 0, '0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
